// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - state type for the serial adder FSM
`include "serial_adder_defs.vh"
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = `ST_IDLE,
        S_RUN  = `ST_RUN,
        S_DONE = `ST_DONE
    } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - request/result bundle; SERIAL_ADDER_OVF_EN adds ovf
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (output start, a, b, c_in, input busy, done, sum, c_out, ovf);
    modport slave  (input start, a, b, c_in, output busy, done, sum, c_out, ovf);
`else
    modport master (output start, a, b, c_in, input busy, done, sum, c_out);
    modport slave  (input start, a, b, c_in, output busy, done, sum, c_out);
`endif
endinterface

// File: rtl/serial_adder_defs.vh
// rtl/serial_adder_defs.vh - shared FSM state encodings for the serial adder
`ifndef SERIAL_ADDER_DEFS_VH
`define SERIAL_ADDER_DEFS_VH
`define ST_IDLE 2'd0
`define ST_RUN  2'd1
`define ST_DONE 2'd2
`endif

// File: rtl/serial_adder_fa_bit.sv
// rtl/serial_adder_fa_bit.sv - combinational 1-bit full adder cell
module fa_bit (
    output logic s,
    output logic c_out,
    input  logic a,
    input  logic b,
    input  logic c_in
);
    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - LSB-first bit-serial adder around one fa_bit cell
// SERIAL_ADDER_OVF_EN adds a signed-overflow flag that updates with sum
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic             w_busy;
    logic             w_done;
    logic             w_last;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum_sr;
    logic [WIDTH-1:0] w_sum_sr_next;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_count;
    logic             r_carry;
    logic             r_c_out;
    logic             w_fa_s;
    logic             w_fa_c;

    fa_bit u_fa (
        .s     (w_fa_s),
        .c_out (w_fa_c),
        .a     (r_a_sr[0]),
        .b     (r_b_sr[0]),
        .c_in  (r_carry)
    );

    // New sum bit enters at the MSB so the result ends up LSB-aligned after WIDTH shifts
    assign w_sum_sr_next = (r_sum_sr >> 1) | (WIDTH'(w_fa_s) << (WIDTH - 1));
    assign w_last        = (r_count == LAST);

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                if (bus.start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end else begin
                    w_next   = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_sum    <= '0;
            r_count  <= '0;
            r_carry  <= 1'b0;
            r_c_out  <= 1'b0;
        end else if (w_accept) begin
            r_a_sr   <= bus.a;
            r_b_sr   <= bus.b;
            r_sum_sr <= '0;
            r_count  <= '0;
            r_carry  <= bus.c_in;
        end else if (r_state == S_RUN) begin
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_sum_sr <= w_sum_sr_next;
            r_carry  <= w_fa_c;
            r_count  <= r_count + 1'b1;
            if (w_last) begin
                r_sum   <= w_sum_sr_next;
                r_c_out <= w_fa_c;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // On the last bit r_carry is the carry into the MSB
    always_ff @(posedge clk) begin
        if (rst)                              r_ovf <= 1'b0;
        else if ((r_state == S_RUN) && w_last) r_ovf <= r_carry ^ w_fa_c;
    end

    assign bus.ovf = r_ovf;
`endif

    assign bus.busy  = w_busy;
    assign bus.done  = w_done;
    assign bus.sum   = r_sum;
    assign bus.c_out = r_c_out;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH=8 and WIDTH=1)
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] last_sum = 8'h00;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) ifc ();
    serial_adder_if #(.WIDTH(1)) ifc1 ();

    serial_adder #(.WIDTH(8)) dut  (.clk(clk), .rst(rst), .bus(ifc.slave));
    serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(ifc1.slave));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
        logic       exp_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: plain integer addition plus sign-rule overflow
    task automatic model(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                         output logic [7:0] s, output logic co, output logic ov);
        int total;
        total = int'(ia) + int'(ib) + int'(ic);
        s  = total[7:0];
        co = total[8];
        ov = (ia[7] == ib[7]) && (s[7] != ia[7]);
    endtask

    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                         input string tag, input bit at_negedge);
        logic [7:0] es;
        logic       ec;
        logic       eo;
        int         nb;
        bit         seen;
        bit         held;
        model(ia, ib, ic, es, ec, eo);
        if (!at_negedge) @(negedge clk);
        ifc.start = 1'b1;
        ifc.a     = ia;
        ifc.b     = ib;
        ifc.c_in  = ic;
        @(negedge clk);
        ifc.start = 1'b0;
        nb   = 0;
        seen = 1'b0;
        held = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (ifc.done) begin
                seen = 1'b1;
            end else begin
                if (ifc.busy) nb++;
                if (ifc.sum !== last_sum) held = 1'b0;
                @(negedge clk);
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_busy_cycles"}, 32'(nb), 32'd8);
        chk({tag, "_sum_held"}, 32'(held), 32'd1);
        chk({tag, "_sum"}, 32'(ifc.sum), 32'(es));
        chk({tag, "_cout"}, 32'(ifc.c_out), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
        chk({tag, "_ovf"}, 32'(ifc.ovf), 32'(eo));
`endif
        last_sum = es;
    endtask

    vec_t vecs[6];

    initial begin
        int dones;
        int nb1;
        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        ifc.start = 1'b0; ifc.a = '0; ifc.b = '0; ifc.c_in = 1'b0;
        ifc1.start = 1'b0; ifc1.a = '0; ifc1.b = '0; ifc1.c_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_done", 32'(ifc.done), 32'd0);
        chk("rst_sum", 32'(ifc.sum), 32'd0);
        chk("rst_cout", 32'(ifc.c_out), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", 32'(ifc.ovf), 32'd0);
`endif
        chk("rst_w1_sum", 32'(ifc1.sum), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, $sformatf("vec%0d", i), 1'b0);
            chk($sformatf("vec%0d_tbl_sum", i), 32'(ifc.sum), 32'(vecs[i].exp_sum));
            chk($sformatf("vec%0d_tbl_cout", i), 32'(ifc.c_out), 32'(vecs[i].exp_cout));
`ifdef SERIAL_ADDER_OVF_EN
            chk($sformatf("vec%0d_tbl_ovf", i), 32'(ifc.ovf), 32'(vecs[i].exp_ovf));
`endif
        end

        for (int i = 0; i < 30; i++)
            do_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i), 1'b0);

        // Start re-pulsed mid-RUN must be ignored
        @(negedge clk);
        ifc.start = 1'b1; ifc.a = 8'h5A; ifc.b = 8'h3C; ifc.c_in = 1'b0;
        dones = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (ifc.done) dones++;
            ifc.start = (i == 3) ? 1'b1 : 1'b0;
            if (i == 3) ifc.a = 8'h11;
        end
        chk("restart_done_count", 32'(dones), 32'd1);
        chk("restart_sum", 32'(ifc.sum), 32'h96);
        last_sum = 8'h96;

        // Back-to-back: new start presented in the DONE cycle
        do_op(8'h5A, 8'h3C, 1'b0, "b2b_first", 1'b0);
        do_op(8'h01, 8'h02, 1'b0, "b2b_second", 1'b1);
        @(negedge clk);
        chk("b2b_done_one_cycle", 32'(ifc.done), 32'd0);

        // Reset at RUN bit 4 aborts the operation
        ifc.start = 1'b1; ifc.a = 8'h5A; ifc.b = 8'h3C; ifc.c_in = 1'b0;
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrun_busy_before", 32'(ifc.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_rst_busy", 32'(ifc.busy), 32'd0);
        chk("midrun_rst_done", 32'(ifc.done), 32'd0);
        chk("midrun_rst_sum", 32'(ifc.sum), 32'd0);
        chk("midrun_rst_cout", 32'(ifc.c_out), 32'd0);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ifc.done) dones++;
        end
        chk("midrun_no_done", 32'(dones), 32'd0);

        // WIDTH=1 instance: 1+1+1 = 3 -> sum 1, carry 1
        ifc1.start = 1'b1; ifc1.a = 1'b1; ifc1.b = 1'b1; ifc1.c_in = 1'b1;
        @(negedge clk);
        ifc1.start = 1'b0;
        nb1 = 0;
        dones = 0;
        for (int i = 0; i < 10 && dones == 0; i++) begin
            if (ifc1.done) dones = 1;
            else begin
                if (ifc1.busy) nb1++;
                @(negedge clk);
            end
        end
        chk("w1_done_seen", 32'(dones), 32'd1);
        chk("w1_busy_cycles", 32'(nb1), 32'd1);
        chk("w1_sum", 32'(ifc1.sum), 32'd1);
        chk("w1_cout", 32'(ifc1.c_out), 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
        chk("w1_ovf", 32'(ifc1.ovf), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
